// File: rtl/pns_axil_regfile_pkg.sv
// -----------------------------------------------------------------------------
// pns_axil_pkg
// Shared definitions for the AXI4-Lite register file:
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   w_state_e / r_state_e   : write and read channel FSM states
//   idx_width()             : ceil(log2(n)), used for index / byte-offset widths
// -----------------------------------------------------------------------------
package pns_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_e;

   // Number of bits needed to index n items (n = 1 gives 0).
   function automatic int idx_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/pns_axil_regfile_if.sv
// -----------------------------------------------------------------------------
// pns_axil_regfile_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) for the register file.
//   ADDR_W : byte address width
//   DATA_W : data width (32 or 64)
// Modports:
//   master : bus initiator (drives addresses, data, valids, bready/rready)
//   slave  : register file side (drives readies, responses, rdata)
// -----------------------------------------------------------------------------
interface pns_axil_regfile_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/pns_axil_regfile.sv
// -----------------------------------------------------------------------------
// pns_axil_regfile
// AXI4-Lite slave register file. The low C_NUM_REGS-C_NUM_RO registers are
// read/write; the top C_NUM_RO indices read live status inputs and reject
// writes with SLVERR. Addresses with any bit above the index field set are
// out of range (SLVERR, read data 0).
// Ports:
//   s00_axi_aclk    : clock, rising edge
//   s00_axi_aresetn : asynchronous active-low reset
//   s00_axi         : AXI4-Lite slave bundle
//   reg_out         : flattened register contents, register i at slice i
//                     (read-only slices stay 0)
//   status_in       : status sources, slice k feeds register C_NUM_REGS-C_NUM_RO+k
//   wr_pulse        : one-cycle strobe per register on an accepted write
// -----------------------------------------------------------------------------
module pns_axil_regfile
   import pns_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_NUM_REGS         = 8,
   parameter int C_NUM_RO           = 2,
   parameter int C_S_AXI_ADDR_WIDTH = idx_width(C_NUM_REGS) + idx_width(C_S_AXI_DATA_WIDTH/8) + 1
) (
   input  logic                                                 s00_axi_aclk,
   input  logic                                                 s00_axi_aresetn,
   pns_axil_regfile_if.slave                                    s00_axi,
   output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]             reg_out,
   input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
   output logic [C_NUM_REGS-1:0]                                wr_pulse
);

   localparam int DW     = C_S_AXI_DATA_WIDTH;
   localparam int SW     = DW / 8;
   localparam int AW     = C_S_AXI_ADDR_WIDTH;
   localparam int OFF_W  = idx_width(SW);
   localparam int IDX_W  = idx_width(C_NUM_REGS);
   localparam int NUM_RW = C_NUM_REGS - C_NUM_RO;

   function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
      return a[IDX_W+OFF_W-1:OFF_W];
   endfunction

   // Any address bit above the index field marks the access out of range.
   function automatic logic addr_oor(input logic [AW-1:0] a);
      return |(a >> (IDX_W + OFF_W));
   endfunction

   // ---------------------------------------------------------------- state
   w_state_e          w_state_q, w_state_d;
   r_state_e          r_state_q, r_state_d;
   logic [AW-1:0]     awaddr_q, awaddr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [SW-1:0]     wstrb_q, wstrb_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [C_NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
   logic [DW-1:0]     regs_q [C_NUM_REGS];
   logic [DW-1:0]     regs_d [C_NUM_REGS];

   // ---------------------------------------------------------------- handshakes
   // Readies decode straight from state so the first edge after reset release
   // can already accept; gating with aresetn keeps them low during reset.
   logic aw_rdy, w_rdy, ar_rdy;
   logic aw_hs, w_hs, ar_hs;

   assign aw_rdy = s00_axi_aresetn && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_W));
   assign w_rdy  = s00_axi_aresetn && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW));
   assign ar_rdy = s00_axi_aresetn && (r_state_q == R_IDLE);

   assign aw_hs = s00_axi.awvalid && aw_rdy;
   assign w_hs  = s00_axi.wvalid  && w_rdy;
   assign ar_hs = s00_axi.arvalid && ar_rdy;

   // ---------------------------------------------------------------- write path
   // The write commits on the edge that completes the last of AW/W, taking
   // whichever half was captured earlier from the holding registers.
   logic [AW-1:0]    cur_addr;
   logic [DW-1:0]    cur_data;
   logic [SW-1:0]    cur_strb;
   logic [IDX_W-1:0] wr_idx;
   logic             wr_ok;
   logic             commit;

   assign cur_addr = (w_state_q == W_HAVE_AW) ? awaddr_q : s00_axi.awaddr;
   assign cur_data = (w_state_q == W_HAVE_W)  ? wdata_q  : s00_axi.wdata;
   assign cur_strb = (w_state_q == W_HAVE_W)  ? wstrb_q  : s00_axi.wstrb;
   assign wr_idx   = addr_idx(cur_addr);
   assign wr_ok    = !addr_oor(cur_addr) && (32'(wr_idx) < 32'(NUM_RW));

   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      commit    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
            end else if (aw_hs) begin
               awaddr_d  = s00_axi.awaddr;
               w_state_d = W_HAVE_AW;
            end else if (w_hs) begin
               wdata_d   = s00_axi.wdata;
               wstrb_d   = s00_axi.wstrb;
               w_state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: if (w_hs)  commit = 1'b1;
         W_HAVE_W:  if (aw_hs) commit = 1'b1;
         W_RESP:    if (s00_axi.bready) w_state_d = W_IDLE;
         default:   w_state_d = W_IDLE;
      endcase
      if (commit) begin
         w_state_d = W_RESP;
         bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_comb begin
      regs_d     = regs_q;
      wr_pulse_d = '0;
      if (commit && wr_ok) begin
         for (int i = 0; i < NUM_RW; i++) begin
            if (wr_idx == IDX_W'(i)) begin
               wr_pulse_d[i] = 1'b1;
               for (int b = 0; b < SW; b++) begin
                  if (cur_strb[b]) regs_d[i][8*b +: 8] = cur_data[8*b +: 8];
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- read path
   // Reads look at regs_q, so a read accepted on the same edge as a write
   // commit returns the pre-write value.
   logic [IDX_W-1:0] rd_idx;
   logic [DW-1:0]    rd_val;

   assign rd_idx = addr_idx(s00_axi.araddr);

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_RW; i++) begin
         if (rd_idx == IDX_W'(i)) rd_val = regs_q[i];
      end
      for (int k = 0; k < C_NUM_RO; k++) begin
         if (rd_idx == IDX_W'(NUM_RW + k)) rd_val = status_in[k*DW +: DW];
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_DATA;
               if (addr_oor(s00_axi.araddr)) begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end else begin
                  rdata_d = rd_val;
                  rresp_d = RESP_OKAY;
               end
            end
         end
         R_DATA:  if (s00_axi.rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         regs_q     <= '{default: '0};
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign s00_axi.awready = aw_rdy;
   assign s00_axi.wready  = w_rdy;
   assign s00_axi.bvalid  = (w_state_q == W_RESP);
   assign s00_axi.bresp   = bresp_q;
   assign s00_axi.arready = ar_rdy;
   assign s00_axi.rvalid  = (r_state_q == R_DATA);
   assign s00_axi.rdata   = rdata_q;
   assign s00_axi.rresp   = rresp_q;
   assign wr_pulse        = wr_pulse_q;

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
      assign reg_out[g*DW +: DW] = regs_q[g];
   end

endmodule

// File: tb/tb_pns_axil_regfile.sv
// -----------------------------------------------------------------------------
// tb_pns_axil_regfile
// Directed bench for pns_axil_regfile with default parameters
// (32-bit data, 8 registers, top 2 read-only, 6-bit byte address).
// -----------------------------------------------------------------------------
module tb_pns_axil_regfile;
   import pns_axil_pkg::*;

   logic         clk;
   logic         aresetn;
   logic [255:0] reg_out;
   logic [63:0]  status_in;
   logic [7:0]   wr_pulse;

   int checks = 0;
   int errors = 0;

   pns_axil_regfile_if #(.ADDR_W(6), .DATA_W(32)) axi ();

   pns_axil_regfile dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (aresetn),
      .s00_axi         (axi.slave),
      .reg_out         (reg_out),
      .status_in       (status_in),
      .wr_pulse        (wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [7:0] pulse, output logic [7:0] stray);
      int n;
      logic aw_f, w_f;
      stray = '0;
      @(negedge clk);
      axi.awaddr  = addr;
      axi.awvalid = 1'b1;
      axi.wdata   = data;
      axi.wstrb   = strb;
      axi.wvalid  = 1'b1;
      n = 0;
      while ((axi.awvalid || axi.wvalid) && n < 20) begin
         aw_f = axi.awvalid && axi.awready;
         w_f  = axi.wvalid && axi.wready;
         @(posedge clk); #1;
         if (aw_f) axi.awvalid = 1'b0;
         if (w_f)  axi.wvalid  = 1'b0;
         if (axi.awvalid || axi.wvalid) begin
            stray |= wr_pulse;
            @(negedge clk);
         end
         n++;
      end
      check("wr_handshake_pending", {axi.awvalid, axi.wvalid}, 2'b00);
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      check("wr_bvalid_latency", axi.bvalid, 1'b1);
      pulse = wr_pulse;
      @(negedge clk);
      resp = axi.bresp;
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      stray |= wr_pulse;
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n;
      logic fired;
      @(negedge clk);
      axi.araddr  = addr;
      axi.arvalid = 1'b1;
      n = 0;
      fired = 1'b0;
      while (!fired && n < 20) begin
         fired = axi.arready;
         @(posedge clk); #1;
         if (!fired) @(negedge clk);
         n++;
      end
      axi.arvalid = 1'b0;
      check("rd_handshake_done", fired, 1'b1);
      check("rd_rvalid_latency", axi.rvalid, 1'b1);
      data = axi.rdata;
      resp = axi.rresp;
      @(negedge clk);
      axi.rready = 1'b1;
      @(posedge clk); #1;
      axi.rready = 1'b0;
   endtask

   typedef struct {
      string       name;
      bit          wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      logic [7:0]  exp_pulse;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input bit wr, input logic [5:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [31:0] exp_data, input logic [1:0] exp_resp,
                               input logic [7:0] exp_pulse);
      vec_t v;
      v.name = name; v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
      v.exp_data = exp_data; v.exp_resp = exp_resp; v.exp_pulse = exp_pulse;
      return v;
   endfunction

   initial begin
      logic [1:0]  resp;
      logic [7:0]  pulse, stray;
      logic [31:0] rd;
      int          bad;

      // write: name, 1, addr, data, strb, -, resp, pulse; read: name, 0, addr, -, -, data, resp, -
      vecs.push_back(mk("w_r0",      1, 6'h00, 32'h1,        4'hF, 0,            RESP_OKAY,   8'h01));
      vecs.push_back(mk("w_r1",      1, 6'h04, 32'h2,        4'hF, 0,            RESP_OKAY,   8'h02));
      vecs.push_back(mk("w_r2",      1, 6'h08, 32'h3,        4'hF, 0,            RESP_OKAY,   8'h04));
      vecs.push_back(mk("w_r3",      1, 6'h0C, 32'h4,        4'hF, 0,            RESP_OKAY,   8'h08));
      vecs.push_back(mk("r_r0",      0, 6'h00, 0,            0,    32'h1,        RESP_OKAY,   0));
      vecs.push_back(mk("r_r1",      0, 6'h04, 0,            0,    32'h2,        RESP_OKAY,   0));
      vecs.push_back(mk("r_r2",      0, 6'h08, 0,            0,    32'h3,        RESP_OKAY,   0));
      vecs.push_back(mk("r_r3",      0, 6'h0C, 0,            0,    32'h4,        RESP_OKAY,   0));
      vecs.push_back(mk("w_full8",   1, 6'h08, 32'hAABBCCDD, 4'hF, 0,            RESP_OKAY,   8'h04));
      vecs.push_back(mk("w_strb5",   1, 6'h08, 32'h11223344, 4'h5, 0,            RESP_OKAY,   8'h04));
      vecs.push_back(mk("r_merge",   0, 6'h08, 0,            0,    32'hAA22CC44, RESP_OKAY,   0));
      vecs.push_back(mk("w_ro7",     1, 6'h1C, 32'hDEAD,     4'hF, 0,            RESP_SLVERR, 8'h00));
      vecs.push_back(mk("r_ro7",     0, 6'h1C, 0,            0,    32'h5A5A,     RESP_OKAY,   0));
      vecs.push_back(mk("r_ro6",     0, 6'h18, 0,            0,    32'h12345678, RESP_OKAY,   0));
      vecs.push_back(mk("r_oor",     0, 6'h20, 0,            0,    32'h0,        RESP_SLVERR, 0));
      vecs.push_back(mk("w_oor",     1, 6'h24, 32'hFFFF,     4'hF, 0,            RESP_SLVERR, 8'h00));
      vecs.push_back(mk("r_r1_oor",  0, 6'h04, 0,            0,    32'h2,        RESP_OKAY,   0));
      vecs.push_back(mk("w_strb0",   1, 6'h10, 32'hCAFEF00D, 4'h0, 0,            RESP_OKAY,   8'h10));
      vecs.push_back(mk("r_r4_off",  0, 6'h13, 0,            0,    32'h0,        RESP_OKAY,   0));
      vecs.push_back(mk("w_r1_off",  1, 6'h05, 32'h55,       4'hF, 0,            RESP_OKAY,   8'h02));
      vecs.push_back(mk("r_r1_new",  0, 6'h04, 0,            0,    32'h55,       RESP_OKAY,   0));

      aresetn     = 1'b0;
      status_in   = {32'h5A5A, 32'h12345678};
      axi.awaddr  = '0; axi.awvalid = 1'b0;
      axi.wdata   = '0; axi.wstrb   = '0; axi.wvalid = 1'b0;
      axi.bready  = 1'b0;
      axi.araddr  = '0; axi.arvalid = 1'b0;
      axi.rready  = 1'b0;

      // reset state
      #12;
      check("rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b000);
      check("rst_valids",  {axi.bvalid, axi.rvalid}, 2'b00);
      check("rst_resp_data", {axi.bresp, axi.rresp, axi.rdata}, 36'h0);
      check("rst_regs_pulse", {reg_out, wr_pulse}, 264'h0);
      @(negedge clk); @(negedge clk);
      aresetn = 1'b1;
      #1;
      check("post_rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);

      // table-driven vectors
      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse, stray);
            check({vecs[i].name, "_bresp"}, resp, vecs[i].exp_resp);
            check({vecs[i].name, "_pulse"}, pulse, vecs[i].exp_pulse);
            check({vecs[i].name, "_stray_pulse"}, stray, 8'h00);
         end else begin
            axi_read(vecs[i].addr, rd, resp);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_data);
            check({vecs[i].name, "_rresp"}, resp, vecs[i].exp_resp);
         end
      end
      check("reg_out_r2", reg_out[2*32 +: 32], 32'hAA22CC44);

      // W three cycles ahead of AW
      @(negedge clk);
      axi.wdata = 32'h0BADBEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      @(posedge clk); #1;
      axi.wvalid = 1'b0;
      check("wfirst_readies", {axi.awready, axi.wready}, 2'b10);
      repeat (3) @(posedge clk);
      @(negedge clk);
      axi.awaddr = 6'h14; axi.awvalid = 1'b1;
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      check("wfirst_bvalid", axi.bvalid, 1'b1);
      check("wfirst_pulse", wr_pulse, 8'h20);
      check("wfirst_reg", reg_out[5*32 +: 32], 32'h0BADBEEF);
      @(negedge clk);
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      check("wfirst_bdone", {axi.bvalid, wr_pulse}, 9'h0);

      // simultaneous read and write to the same register
      @(negedge clk);
      axi.awaddr = 6'h00; axi.awvalid = 1'b1;
      axi.wdata = 32'h99; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      axi.araddr = 6'h00; axi.arvalid = 1'b1;
      @(posedge clk); #1;
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      check("rw_same_valids", {axi.bvalid, axi.rvalid}, 2'b11);
      check("rw_same_old_data", axi.rdata, 32'h1);
      @(negedge clk);
      axi.bready = 1'b1; axi.rready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0; axi.rready = 1'b0;
      axi_read(6'h00, rd, resp);
      check("rw_same_new_data", rd, 32'h99);

      // response back-pressure
      @(negedge clk);
      axi.awaddr = 6'h0C; axi.awvalid = 1'b1;
      axi.wdata = 32'h44; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      @(posedge clk); #1;
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!(axi.bvalid && !axi.awready && !axi.wready)) bad++;
      end
      check("bhold_bad_cycles", bad, 0);
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      check("bhold_release", {axi.bvalid, axi.awready, axi.wready}, 3'b011);

      // reset while holding an address
      @(negedge clk);
      axi.awaddr = 6'h00; axi.awvalid = 1'b1;
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      check("haveaw_readies", {axi.awready, axi.wready}, 2'b01);
      #2;
      aresetn = 1'b0;
      #1;
      check("arst_readies", {axi.awready, axi.wready, axi.arready}, 3'b000);
      check("arst_valids", {axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata}, 38'h0);
      check("arst_regs", {reg_out, wr_pulse}, 264'h0);
      @(negedge clk); @(negedge clk);
      aresetn = 1'b1;
      #1;
      check("arst_post_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);
      axi_read(6'h00, rd, resp);
      check("arst_r0", {rd, resp}, {32'h0, RESP_OKAY});
      axi_read(6'h14, rd, resp);
      check("arst_r5", {rd, resp}, {32'h0, RESP_OKAY});
      check("arst_no_pending_b", axi.bvalid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
